// File: rtl/sram_access_seq.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_seq
// Brief    : AVR command front end for the SRAM bridge: address register with
//            auto-increment and timed active-low we_n/oe_n access strobes.
// Revision : 1.0  initial release
// ============================================================================
module sram_access_seq #(
    parameter int AWIDTH = 21,
    parameter int SETUP  = 1,
    parameter int PULSE  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd,
    input  logic [7:0]        cmd_data,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] sram_addr,
    output logic              we_n,
    output logic              oe_n,
    output logic              auto_inc
);

    localparam logic [3:0] c_st_idle   = 4'b0001;
    localparam logic [3:0] c_st_setup  = 4'b0010;
    localparam logic [3:0] c_st_strobe = 4'b0100;
    localparam logic [3:0] c_st_hold   = 4'b1000;

    localparam logic [2:0] c_cmd_load_lo  = 3'd0;
    localparam logic [2:0] c_cmd_load_mid = 3'd1;
    localparam logic [2:0] c_cmd_load_hi  = 3'd2;
    localparam logic [2:0] c_cmd_read     = 3'd3;
    localparam logic [2:0] c_cmd_write    = 3'd4;
    localparam logic [2:0] c_cmd_inc_on   = 3'd5;
    localparam logic [2:0] c_cmd_inc_off  = 3'd6;

    // Counter holds remaining cycles minus one, so max(SETUP,PULSE)-1 must fit.
    localparam int c_cmax = (SETUP > PULSE) ? SETUP : PULSE;
    localparam int c_cw   = (c_cmax > 1) ? $clog2(c_cmax) : 1;
    localparam logic [c_cw-1:0] c_setup_ld = c_cw'(SETUP - 1);
    localparam logic [c_cw-1:0] c_pulse_ld = c_cw'(PULSE - 1);

    logic [3:0]      r_state;
    logic [c_cw-1:0] r_cnt;
    logic            r_is_write;
    logic            w_accept;

    assign w_accept = cmd_valid && !busy && (r_state == c_st_idle);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sram_addr  <= '0;
            we_n       <= 1'b1;
            oe_n       <= 1'b1;
            auto_inc   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        case (cmd)
                            c_cmd_load_lo:  sram_addr[7:0]        <= cmd_data;
                            c_cmd_load_mid: sram_addr[15:8]       <= cmd_data;
                            c_cmd_load_hi:  sram_addr[AWIDTH-1:16] <= cmd_data[AWIDTH-17:0];
                            c_cmd_read, c_cmd_write: begin
                                r_is_write <= (cmd == c_cmd_write);
                                r_state    <= c_st_setup;
                                r_cnt      <= c_setup_ld;
                                busy       <= 1'b1;
                            end
                            c_cmd_inc_on:   auto_inc <= 1'b1;
                            c_cmd_inc_off:  auto_inc <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                c_st_setup: begin
                    if (r_cnt == '0) begin
                        // Strobes are registered, so they fall on the STROBE entry edge.
                        r_state <= c_st_strobe;
                        r_cnt   <= c_pulse_ld;
                        we_n    <= ~r_is_write;
                        oe_n    <= r_is_write;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_st_strobe: begin
                    if (r_cnt == '0) begin
                        r_state <= c_st_hold;
                        r_cnt   <= '0;
                        we_n    <= 1'b1;
                        oe_n    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_st_hold: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    if (auto_inc)
                        sram_addr <= sram_addr + AWIDTH'(1);
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                    we_n    <= 1'b1;
                    oe_n    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sram_access_seq.md
Name: sram_access_seq

Overview:
- Upstream command stage for the AVR-to-SRAM bus bridge in the CPLD.
- Takes byte-wide commands from the AVR, holds the SRAM address register and auto-increments it.
- Generates timed, active-low SRAM write and output-enable strobes (we_n, oe_n). These strobes drive the we/oe inputs of the data bus FSM.
- Gives the AVR a busy/done handshake, so firmware can stream sequential bytes without reloading the address.

Parameters:
- AWIDTH, 21, SRAM address width in bits; legal range 17..24.
- SETUP, 1, cycles the address is stable before a strobe asserts; minimum 1.
- PULSE, 3, cycles a strobe is held low; minimum 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  AVR command strobe; sampled each clock.
- cmd  input  3  command code:
  - 0 LOAD_LO, 1 LOAD_MID, 2 LOAD_HI
  - 3 READ, 4 WRITE
  - 5 INC_ON, 6 INC_OFF
  - 7 NOP
- cmd_data  input  8  address byte for the LOAD_* commands.
- busy  output  1  high while a READ or WRITE access is in progress.
- done  output  1  one-cycle pulse when an access completes.
- sram_addr  output  AWIDTH  current SRAM address (registered).
- we_n  output  1  SRAM/bus write strobe, active low (registered).
- oe_n  output  1  SRAM/bus read strobe, active low (registered).
- auto_inc  output  1  current auto-increment mode.

Behaviour:
- Reset values (synchronous): sram_addr=0, we_n=1, oe_n=1, busy=0, done=0, auto_inc=1, state=IDLE.
- Reset has priority over every other input, including mid-access. Strobes return high on the reset edge; no done pulse is issued.
- Command acceptance:
  - A command is accepted on an edge where cmd_valid=1, busy=0 and state=IDLE.
  - A command presented while busy=1 is dropped, not queued.
  - NOP and unused codes have no effect.
- Address loads take effect on the accepting edge:
  - LOAD_LO sets addr[7:0] = cmd_data.
  - LOAD_MID sets addr[15:8] = cmd_data.
  - LOAD_HI sets addr[AWIDTH-1:16] = cmd_data[AWIDTH-17:0]. Data bits above the address width are ignored.
  - No other address bits change.
- INC_ON / INC_OFF set or clear auto_inc on the accepting edge.
- Access state machine, one-hot: IDLE, SETUP, STROBE, HOLD.
  - IDLE -> SETUP on an accepted READ or WRITE. The access type is latched; busy=1 from the following cycle.
  - SETUP holds for SETUP cycles; both strobes stay high.
  - STROBE holds for PULSE cycles. we_n=0 for WRITE, oe_n=0 for READ; the other strobe stays high.
  - HOLD lasts 1 cycle with both strobes high, so data hold time is met at the bus FSM.
  - HOLD -> IDLE. In the first IDLE cycle, busy=0 and done=1 for exactly one cycle.
- Latency:
  - busy is high for SETUP+PULSE+1 cycles.
  - With defaults: 5 cycles busy; strobe low in cycles 2..4 after the accept edge; done in cycle 6.
  - A new command may be accepted on the same edge where done is high.
- One wait counter, wide enough for max(SETUP,PULSE), is reused across states and reloaded on every state entry.
- Auto-increment: if auto_inc=1, sram_addr increments by 1 on the HOLD->IDLE edge.
  - It wraps from 2^AWIDTH-1 to 0 with no flag.
  - If auto_inc=0, the address is unchanged.
- sram_addr must not change during SETUP, STROBE or HOLD.
- Invariant: we_n and oe_n are never low in the same cycle, and neither is ever low outside STROBE.
- Outputs are registered and glitch-free, as required for CPLD pin timing.

Test Plan:
- Reset then idle: after a reset pulse, sram_addr=0, we_n=oe_n=1, busy=0, auto_inc=1. No strobe activity for 20 cycles with cmd_valid=0.
- Address load: LOAD_LO 0x34, LOAD_MID 0x12, LOAD_HI 0xFF (AWIDTH=21) -> sram_addr=0x1F1234. The upper bits of 0xFF are discarded.
- Write timing (defaults): WRITE at addr 0x000010 -> busy high for 5 cycles; we_n low exactly cycles 2-4; oe_n stays 1; done pulses once; sram_addr=0x000011 afterwards.
- Read with INC_OFF: INC_OFF, then READ at 0x0000FF -> oe_n low for 3 cycles; we_n stays 1; sram_addr remains 0x0000FF after done.
- Busy collision and wrap: load 0x1FFFFF, WRITE, then issue LOAD_LO 0x00 and READ while busy -> both dropped. Address wraps to 0x000000; a READ issued on the done cycle is accepted.
- Reset mid-access: assert reset during STROBE of a WRITE -> we_n=1 on that edge, busy=0, sram_addr=0, no done pulse.
